// File: rtl/card_dealer.sv
// Deals random cards without replacement from a single 52-card deck on request.
// Optional build macro: CARD_DEALER_FIXED_ORDER_EN (PICK starts at idx 0 for deterministic dealing).
module card_dealer #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       shuffle,
    input  logic       draw_req,
    output logic       busy,
    output logic       card_valid,
    output logic [1:0] card_symbol,
    output logic [3:0] card_number,
    output logic [5:0] cards_left,
    output logic       deck_empty
);

    localparam int unsigned DECK_SIZE = 52;
    localparam int unsigned IDX_W     = 6;
    localparam int unsigned LFSR_W    = 16;
    localparam int unsigned SUIT_LEN  = 13;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
    localparam logic [LFSR_W-1:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PICK = 2'd1,
        SCAN = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [LFSR_W-1:0]      lfsr_q, lfsr_d;
    logic [DECK_SIZE-1:0]   used_q, used_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [IDX_W-1:0]       cards_left_q, cards_left_d;
    logic                   deck_empty_q, deck_empty_d;
    logic                   busy_q, busy_d;
    logic                   card_valid_q, card_valid_d;
    logic [1:0]             card_symbol_q, card_symbol_d;
    logic [3:0]             card_number_q, card_number_d;

    logic                   slot_used_c;
    logic [1:0]             sym_c;
    logic [IDX_W-1:0]       rem_c;
    logic [IDX_W-1:0]       pick_idx_c;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign slot_used_c = used_q[idx_q];

    // Next-state logic; shuffle aborts any deal in flight
    always_comb begin
        state_d = state_q;
        if (shuffle) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (draw_req && !deck_empty_q) state_d = PICK;
                PICK: state_d = SCAN;
                SCAN: if (!slot_used_c) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Suit/rank from idx by compare-subtract against suit boundaries
    always_comb begin
        sym_c = 2'd0;
        rem_c = idx_q;
        if (idx_q >= IDX_W'(3 * SUIT_LEN)) begin
            sym_c = 2'd3;
            rem_c = idx_q - IDX_W'(3 * SUIT_LEN);
        end else if (idx_q >= IDX_W'(2 * SUIT_LEN)) begin
            sym_c = 2'd2;
            rem_c = idx_q - IDX_W'(2 * SUIT_LEN);
        end else if (idx_q >= IDX_W'(SUIT_LEN)) begin
            sym_c = 2'd1;
            rem_c = idx_q - IDX_W'(SUIT_LEN);
        end
    end

`ifdef CARD_DEALER_FIXED_ORDER_EN
    assign pick_idx_c = '0;
`else
    assign pick_idx_c = (lfsr_q[IDX_W-1:0] >= IDX_W'(DECK_SIZE))
                      ? lfsr_q[IDX_W-1:0] - IDX_W'(DECK_SIZE)
                      : lfsr_q[IDX_W-1:0];
`endif

    // Datapath and output next values
    always_comb begin
        lfsr_d        = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
        used_d        = used_q;
        idx_d         = idx_q;
        cards_left_d  = cards_left_q;
        card_valid_d  = 1'b0;
        card_symbol_d = card_symbol_q;
        card_number_d = card_number_q;
        if (shuffle) begin
            used_d       = '0;
            cards_left_d = IDX_W'(DECK_SIZE);
        end else begin
            unique case (state_q)
                PICK: idx_d = pick_idx_c;
                SCAN: begin
                    if (slot_used_c) begin
                        idx_d = (idx_q == IDX_W'(DECK_SIZE - 1)) ? '0 : idx_q + IDX_W'(1);
                    end else begin
                        used_d[idx_q] = 1'b1;
                        card_symbol_d = sym_c;
                        card_number_d = 4'(rem_c) + 4'd1;
                        card_valid_d  = 1'b1;
                        cards_left_d  = cards_left_q - IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
        deck_empty_d = (cards_left_d == '0);
        busy_d       = (state_d != IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_q        <= SEED_EFF;
            used_q        <= '0;
            idx_q         <= '0;
            cards_left_q  <= IDX_W'(DECK_SIZE);
            deck_empty_q  <= 1'b0;
            busy_q        <= 1'b0;
            card_valid_q  <= 1'b0;
            card_symbol_q <= '0;
            card_number_q <= '0;
        end else begin
            lfsr_q        <= lfsr_d;
            used_q        <= used_d;
            idx_q         <= idx_d;
            cards_left_q  <= cards_left_d;
            deck_empty_q  <= deck_empty_d;
            busy_q        <= busy_d;
            card_valid_q  <= card_valid_d;
            card_symbol_q <= card_symbol_d;
            card_number_q <= card_number_d;
        end
    end

    assign busy        = busy_q;
    assign card_valid  = card_valid_q;
    assign card_symbol = card_symbol_q;
    assign card_number = card_number_q;
    assign cards_left  = cards_left_q;
    assign deck_empty  = deck_empty_q;

endmodule

// File: tb/tb_card_dealer.sv
// Scoreboard bench for card_dealer: a reference deck/LFSR model predicts each dealt card.
module tb_card_dealer;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst;
    logic       shuffle;
    logic       draw_req;
    logic       busy;
    logic       card_valid;
    logic [1:0] card_symbol;
    logic [3:0] card_number;
    logic [5:0] cards_left;
    logic       deck_empty;

    card_dealer #(.LFSR_SEED(SEED)) dut (
        .clk         (clk),
        .rst         (rst),
        .shuffle     (shuffle),
        .draw_req    (draw_req),
        .busy        (busy),
        .card_valid  (card_valid),
        .card_symbol (card_symbol),
        .card_number (card_number),
        .cards_left  (cards_left),
        .deck_empty  (deck_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sym;
        int num;
        int left;
        int lat;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] m_lfsr;
    bit          m_used[52];
    int          m_left;
    bit          seen[4][14];

    // Reference LFSR: x^16+x^14+x^13+x^11+1, Galois form, steps every cycle out of reset
    always @(posedge clk) begin
        if (!rst) m_lfsr <= SEED;
        else      m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        foreach (m_used[i]) m_used[i] = 1'b0;
        m_left = 52;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_busy"},  busy, 0);
        check_eq({tag, "_valid"}, card_valid, 0);
        check_eq({tag, "_sym"},   card_symbol, 0);
        check_eq({tag, "_num"},   card_number, 0);
        check_eq({tag, "_left"},  cards_left, 52);
        check_eq({tag, "_empty"}, deck_empty, 0);
    endtask

    // One accepted draw; optionally re-pulses draw_req while busy, which must be ignored
    task automatic deal_one(input bit extra_req);
        int   r, idx, k, lat;
        bit   got;
        exp_t e;
        @(negedge clk) draw_req = 1'b1;
        @(posedge clk);
        #1 draw_req = 1'b0;
        r = int'(m_lfsr[5:0]);
`ifdef CARD_DEALER_FIXED_ORDER_EN
        idx = 0;
`else
        idx = (r >= 52) ? r - 52 : r;
`endif
        k = 0;
        while (m_used[idx]) begin
            idx = (idx == 51) ? 0 : idx + 1;
            k++;
        end
        m_used[idx] = 1'b1;
        m_left--;
        sb.push_back('{sym: idx / 13, num: (idx % 13) + 1, left: m_left, lat: 2 + k});
        lat = 0;
        got = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (extra_req && c == 0) draw_req = 1'b1;
            @(posedge clk);
            #1 draw_req = 1'b0;
            lat++;
            if (card_valid) begin
                got = 1'b1;
                break;
            end
        end
        check_eq("valid_seen", got, 1);
        e = sb.pop_front();
        if (got) begin
            check_eq("symbol",  card_symbol, e.sym);
            check_eq("number",  card_number, e.num);
            check_eq("left",    cards_left, e.left);
            check_eq("latency", lat, e.lat);
            check_eq("empty",   deck_empty, (e.left == 0) ? 1 : 0);
            seen[card_symbol][card_number] = 1'b1;
        end
        @(posedge clk);
        #1;
        check_eq("valid_pulse", card_valid, 0);
        check_eq("idle_after",  busy, 0);
    endtask

    task automatic pulse_shuffle();
        @(negedge clk) shuffle = 1'b1;
        @(posedge clk);
        #1 shuffle = 1'b0;
        model_clear();
    endtask

    task automatic count_valid(input int cycles, output int cnt);
        cnt = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            if (card_valid) cnt++;
        end
    endtask

    initial begin
        int         cnt, distinct;
        logic [1:0] hold_sym;
        logic [3:0] hold_num;

        rst = 1'b0;
        shuffle = 1'b0;
        draw_req = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 check_reset_vals("reset");
        @(negedge clk) rst = 1'b1;

        // Full deck: every card distinct, deck empties on the last deal
        for (int i = 0; i < 52; i++) deal_one(i % 7 == 3);
        check_eq("final_left",  cards_left, 0);
        check_eq("final_empty", deck_empty, 1);
        distinct = 0;
        for (int s = 0; s < 4; s++)
            for (int n = 1; n <= 13; n++)
                if (seen[s][n]) distinct++;
        check_eq("distinct_cards", distinct, 52);

        // Draw on empty deck is ignored and outputs hold
        hold_sym = card_symbol;
        hold_num = card_number;
        @(negedge clk) draw_req = 1'b1;
        @(posedge clk);
        #1 draw_req = 1'b0;
        check_eq("empty_busy", busy, 0);
        count_valid(6, cnt);
        check_eq("empty_no_valid", cnt, 0);
        check_eq("empty_sym_hold", card_symbol, hold_sym);
        check_eq("empty_num_hold", card_number, hold_num);

        pulse_shuffle();
        check_eq("shuf_left",  cards_left, 52);
        check_eq("shuf_empty", deck_empty, 0);
        check_eq("shuf_busy",  busy, 0);

        // Shuffle during SCAN after 20 deals aborts the in-flight card
        for (int i = 0; i < 20; i++) deal_one(1'b0);
        hold_sym = card_symbol;
        hold_num = card_number;
        @(negedge clk) draw_req = 1'b1;
        @(posedge clk);
        #1 draw_req = 1'b0;
        @(posedge clk);
        #1 check_eq("scan_busy", busy, 1);
        shuffle = 1'b1;
        @(posedge clk);
        #1 shuffle = 1'b0;
        model_clear();
        check_eq("abort_valid", card_valid, 0);
        check_eq("abort_left",  cards_left, 52);
        check_eq("abort_busy",  busy, 0);
        check_eq("abort_sym",   card_symbol, hold_sym);
        check_eq("abort_num",   card_number, hold_num);
        count_valid(4, cnt);
        check_eq("abort_no_valid", cnt, 0);

        // Shuffle and draw in the same cycle: shuffle wins
        @(negedge clk) begin
            shuffle = 1'b1;
            draw_req = 1'b1;
        end
        @(posedge clk);
        #1 begin
            shuffle = 1'b0;
            draw_req = 1'b0;
        end
        check_eq("both_busy", busy, 0);
        count_valid(4, cnt);
        check_eq("both_no_valid", cnt, 0);
        check_eq("both_left", cards_left, 52);

        deal_one(1'b0);

        // Reset during PICK
        @(negedge clk) draw_req = 1'b1;
        @(posedge clk);
        #1 draw_req = 1'b0;
        check_eq("pick_busy", busy, 1);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 check_reset_vals("midrst");
        @(negedge clk) rst = 1'b1;
        model_clear();
        count_valid(3, cnt);
        check_eq("midrst_no_valid", cnt, 0);
        check_eq("midrst_left", cards_left, 52);
        for (int i = 0; i < 3; i++) deal_one(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
